// File: rtl/rf_wb_queue.sv
// rf_wb_queue: writeback queue feeding the 8x16 register file write port.
// Pushes are buffered in a small circular FIFO and drained one per cycle in
// arrival order. Two lookup ports expose the newest still-pending value per
// register so decode never reads stale rf contents.
// Optional feature macro: WBQ_COALESCE_EN (merge a push into the youngest
// entry when it targets the same register and that entry is not draining).
module rf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enq,
    input  logic [2:0]  enq_reg,
    input  logic [15:0] enq_data,
    output logic        enq_ready,
    input  logic        hold,
    output logic [2:0]  writeregsel,
    output logic [15:0] writedata,
    output logic        write,
    input  logic [2:0]  lk1sel,
    output logic        lk1hit,
    output logic [15:0] lk1data,
    input  logic [2:0]  lk2sel,
    output logic        lk2hit,
    output logic [15:0] lk2data,
    output logic        empty,
    output logic        err
);

    localparam int CW = PTRW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [2:0]  rsel;
        logic [15:0] data;
    } wb_ent_t;

    wb_ent_t         mem [DEPTH];
    logic [PTRW-1:0] head;
    logic [PTRW-1:0] tail;
    logic [PTRW-1:0] tail_m1;
    logic [CW-1:0]   count;
    logic            full;
    logic            coal;
    logic            push_alloc;
    logic            push_coal;
    logic [PTRW-1:0] idx;

    assign tail_m1     = tail - 1'b1;
    assign empty       = (count == '0);
    assign full        = (count == FULL_CNT);
    assign write       = !empty && !hold;
    assign writeregsel = mem[head].rsel;
    assign writedata   = mem[head].data;

`ifdef WBQ_COALESCE_EN
    // youngest entry is mergeable unless it is the head leaving this cycle
    assign coal = !empty && (mem[tail_m1].rsel == enq_reg) &&
                  !(write && (count == CW'(1)));
`else
    assign coal = 1'b0;
`endif

    assign enq_ready  = !full || coal;
    assign push_coal  = enq && coal;
    assign push_alloc = enq && !coal && !full;

    // scan valid entries oldest to youngest so the youngest match wins
    always_comb begin
        lk1hit  = 1'b0;
        lk1data = '0;
        lk2hit  = 1'b0;
        lk2data = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTRW'(i);
            if (CW'(i) < count) begin
                if (mem[idx].rsel == lk1sel) begin
                    lk1hit  = 1'b1;
                    lk1data = mem[idx].data;
                end
                if (mem[idx].rsel == lk2sel) begin
                    lk2hit  = 1'b1;
                    lk2data = mem[idx].data;
                end
            end
        end
    end

    // queue state: push/coalesce, drain, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_alloc) begin
                mem[tail] <= '{rsel: enq_reg, data: enq_data};
                tail      <= tail + 1'b1;
            end
            if (push_coal) mem[tail_m1].data <= enq_data;
            if (write) head <= head + 1'b1;
            count <= count + CW'(push_alloc) - CW'(write);
            if (enq && !enq_ready) err <= 1'b1;
        end
    end

endmodule
